// File: rtl/midi_voice_allocator.sv
// MIDI Note On/Off parser with running status, driving a fixed voice pool with LRU stealing.
// Optional MIDI_CHANNEL_FILTER_EN: accept note messages only on CHANNEL (otherwise omni).
module midi_voice_allocator #(
    parameter int         VOICES  = 4,
    parameter logic [3:0] CHANNEL = 4'd0,
    localparam int        VW      = $clog2(VOICES)
) (
    input  logic                  CLOCK_50,
    input  logic                  RESET,
    input  logic                  isByteAvailable,
    input  logic [7:0]            byteValue,
    output logic [VOICES-1:0]     voiceGate,
    output logic [7*VOICES-1:0]   voiceNote,
    output logic [7*VOICES-1:0]   voiceVelocity,
    output logic                  noteEvent,
    output logic [VW-1:0]         eventVoice
);

`ifdef MIDI_CHANNEL_FILTER_EN
    localparam bit FILTER_EN = 1'b1;
`else
    localparam bit FILTER_EN = 1'b0;
`endif

    typedef enum logic [1:0] {ST_IDLE, ST_DATA1, ST_DATA2} state_t;

    state_t         state_q, state_d;
    logic           run_on_q, run_on_d;
    logic [6:0]     data1_q, data1_d;

    logic [VOICES-1:0] gate_q, gate_d;
    logic [6:0]        note_q [VOICES];
    logic [6:0]        note_d [VOICES];
    logic [6:0]        vel_q  [VOICES];
    logic [6:0]        vel_d  [VOICES];
    logic [VW-1:0]     rank_q [VOICES];
    logic [VW-1:0]     rank_d [VOICES];
    logic              note_event_q, note_event_d;
    logic [VW-1:0]     event_voice_q, event_voice_d;

    logic          is_realtime, is_note_status, chan_ok;
    logic          msg_done, msg_on;
    logic [6:0]    msg_note, msg_vel;
    logic          hit_found, free_found;
    logic [VW-1:0] hit_idx, free_idx, steal_idx, sel_idx, off_idx;
    logic [VOICES-1:0] off_mask;

    assign is_realtime    = (byteValue[7:3] == 5'b11111);
    assign is_note_status = (byteValue[7:5] == 3'b100);
    assign chan_ok        = !FILTER_EN || (byteValue[3:0] == CHANNEL);

    // Parser state register
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            state_q  <= ST_IDLE;
            run_on_q <= 1'b0;
            data1_q  <= 7'd0;
        end else begin
            state_q  <= state_d;
            run_on_q <= run_on_d;
            data1_q  <= data1_d;
        end
    end

    // Parser next state; realtime bytes leave everything untouched
    always_comb begin
        state_d  = state_q;
        run_on_d = run_on_q;
        data1_d  = data1_q;
        if (isByteAvailable) begin
            if (byteValue[7]) begin
                if (!is_realtime) begin
                    if (is_note_status && chan_ok) begin
                        run_on_d = byteValue[4];
                        state_d  = ST_DATA1;
                    end else begin
                        run_on_d = 1'b0;
                        state_d  = ST_IDLE;
                    end
                end
            end else begin
                case (state_q)
                    ST_DATA1: begin
                        data1_d = byteValue[6:0];
                        state_d = ST_DATA2;
                    end
                    ST_DATA2: state_d = ST_DATA1;
                    default:  state_d = state_q;
                endcase
            end
        end
    end

    // Parser outputs: a completed message and its decoded meaning
    always_comb begin
        msg_done = isByteAvailable && !byteValue[7] && (state_q == ST_DATA2);
        msg_on   = run_on_q && (byteValue[6:0] != 7'd0);
        msg_note = data1_q;
        msg_vel  = byteValue[6:0];
    end

    always_comb begin
        gate_d        = gate_q;
        note_d        = note_q;
        vel_d         = vel_q;
        rank_d        = rank_q;
        note_event_d  = 1'b0;
        event_voice_d = event_voice_q;
        hit_found     = 1'b0;
        free_found    = 1'b0;
        hit_idx       = '0;
        free_idx      = '0;
        steal_idx     = '0;
        off_idx       = '0;
        off_mask      = '0;
        sel_idx       = '0;
        // Descending scan so the lowest matching index wins
        for (int v = VOICES - 1; v >= 0; v--) begin
            if (gate_q[v] && note_q[v] == msg_note) begin
                hit_found = 1'b1;
                hit_idx   = VW'(v);
                off_idx   = VW'(v);
                off_mask[v] = 1'b1;
            end
            if (!gate_q[v]) begin
                free_found = 1'b1;
                free_idx   = VW'(v);
            end
            if (rank_q[v] == VW'(VOICES - 1))
                steal_idx = VW'(v);
        end
        if (msg_done) begin
            if (msg_on) begin
                sel_idx = hit_found ? hit_idx : (free_found ? free_idx : steal_idx);
                gate_d[sel_idx] = 1'b1;
                note_d[sel_idx] = msg_note;
                vel_d[sel_idx]  = msg_vel;
                for (int u = 0; u < VOICES; u++) begin
                    if (rank_q[u] < rank_q[sel_idx])
                        rank_d[u] = rank_q[u] + VW'(1);
                end
                rank_d[sel_idx] = '0;
                note_event_d    = 1'b1;
                event_voice_d   = sel_idx;
            end else if (off_mask != '0) begin
                gate_d        = gate_q & ~off_mask;
                note_event_d  = 1'b1;
                event_voice_d = off_idx;
            end
        end
    end

    // Voice registers
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            gate_q        <= '0;
            note_event_q  <= 1'b0;
            event_voice_q <= '0;
            for (int v = 0; v < VOICES; v++) begin
                note_q[v] <= 7'd0;
                vel_q[v]  <= 7'd0;
                rank_q[v] <= VW'(v);
            end
        end else begin
            gate_q        <= gate_d;
            note_event_q  <= note_event_d;
            event_voice_q <= event_voice_d;
            note_q        <= note_d;
            vel_q         <= vel_d;
            rank_q        <= rank_d;
        end
    end

    always_comb begin
        voiceGate     = gate_q;
        noteEvent     = note_event_q;
        eventVoice    = event_voice_q;
        voiceNote     = '0;
        voiceVelocity = '0;
        for (int v = 0; v < VOICES; v++) begin
            voiceNote[7*v +: 7]     = note_q[v];
            voiceVelocity[7*v +: 7] = vel_q[v];
        end
    end

endmodule

// File: tb/tb_midi_voice_allocator.sv
// Scoreboard bench for midi_voice_allocator: a timestamp-based reference model predicts each noteEvent.
module tb_midi_voice_allocator;

    localparam int VOICES = 4;
    localparam int VW     = $clog2(VOICES);

    logic                CLOCK_50 = 1'b0;
    logic                RESET    = 1'b0;
    logic                isByteAvailable = 1'b0;
    logic [7:0]          byteValue = 8'd0;
    logic [VOICES-1:0]   voiceGate;
    logic [7*VOICES-1:0] voiceNote;
    logic [7*VOICES-1:0] voiceVelocity;
    logic                noteEvent;
    logic [VW-1:0]       eventVoice;

    midi_voice_allocator #(.VOICES(VOICES), .CHANNEL(4'd0)) dut (
        .CLOCK_50        (CLOCK_50),
        .RESET           (RESET),
        .isByteAvailable (isByteAvailable),
        .byteValue       (byteValue),
        .voiceGate       (voiceGate),
        .voiceNote       (voiceNote),
        .voiceVelocity   (voiceVelocity),
        .noteEvent       (noteEvent),
        .eventVoice      (eventVoice)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        int                  voice;
        logic [VOICES-1:0]   gate;
        logic [7*VOICES-1:0] notes;
        logic [7*VOICES-1:0] vels;
    } exp_t;

    exp_t sb_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model: recency tracked with allocation timestamps
    int         m_state;
    logic       m_on;
    logic [6:0] m_d1;
    logic       m_gate [VOICES];
    logic [6:0] m_note [VOICES];
    logic [6:0] m_vel  [VOICES];
    int         m_stamp[VOICES];
    int         m_time;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [VOICES-1:0] m_gates();
        logic [VOICES-1:0] g;
        for (int i = 0; i < VOICES; i++) g[i] = m_gate[i];
        return g;
    endfunction

    task automatic m_reset();
        m_state = 0; m_on = 1'b0; m_d1 = 7'd0; m_time = 0;
        for (int i = 0; i < VOICES; i++) begin
            m_gate[i] = 1'b0; m_note[i] = 7'd0; m_vel[i] = 7'd0; m_stamp[i] = -i;
        end
        sb_q.delete();
    endtask

    task automatic m_push(input int v);
        exp_t e;
        e.voice = v;
        e.gate  = m_gates();
        for (int i = 0; i < VOICES; i++) begin
            e.notes[7*i +: 7] = m_note[i];
            e.vels[7*i +: 7]  = m_vel[i];
        end
        sb_q.push_back(e);
    endtask

    task automatic m_apply(input logic [6:0] n, input logic [6:0] k);
        int v;
        v = -1;
        if (m_on && k != 7'd0) begin
            for (int i = 0; i < VOICES && v < 0; i++)
                if (m_gate[i] && m_note[i] == n) v = i;
            for (int i = 0; i < VOICES && v < 0; i++)
                if (!m_gate[i]) v = i;
            if (v < 0) begin
                v = 0;
                for (int i = 1; i < VOICES; i++)
                    if (m_stamp[i] < m_stamp[v]) v = i;
            end
            m_gate[v] = 1'b1; m_note[v] = n; m_vel[v] = k;
            m_time++; m_stamp[v] = m_time;
            m_push(v);
        end else begin
            for (int i = 0; i < VOICES; i++)
                if (m_gate[i] && m_note[i] == n) begin
                    m_gate[i] = 1'b0;
                    if (v < 0) v = i;
                end
            if (v >= 0) m_push(v);
        end
    endtask

    task automatic m_byte(input logic [7:0] b);
        logic ch_ok;
`ifdef MIDI_CHANNEL_FILTER_EN
        ch_ok = (b[3:0] == 4'd0);
`else
        ch_ok = 1'b1;
`endif
        if (b >= 8'hF8) begin
        end else if (b >= 8'h80) begin
            if (b < 8'hA0 && ch_ok) begin m_on = b[4]; m_state = 1; end
            else begin m_on = 1'b0; m_state = 0; end
        end else if (m_state == 1) begin
            m_d1 = b[6:0]; m_state = 2;
        end else if (m_state == 2) begin
            m_state = 1;
            m_apply(m_d1, b[6:0]);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        exp_t e;
        @(negedge CLOCK_50);
        isByteAvailable = 1'b1;
        byteValue       = b;
        m_byte(b);
        @(posedge CLOCK_50);
        #1;
        isByteAvailable = 1'b0;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("note_event", 64'(noteEvent), 64'd1);
            chk("event_voice", 64'(eventVoice), 64'(e.voice));
            chk("voice_gate", 64'(voiceGate), 64'(e.gate));
            chk("voice_note", 64'(voiceNote), 64'(e.notes));
            chk("voice_vel", 64'(voiceVelocity), 64'(e.vels));
        end else begin
            chk("no_event", 64'(noteEvent), 64'd0);
            chk("gate_hold", 64'(voiceGate), 64'(m_gates()));
        end
    endtask

    task automatic idle_cycle();
        @(negedge CLOCK_50);
        @(posedge CLOCK_50);
        #1;
        chk("event_low", 64'(noteEvent), 64'd0);
    endtask

    task automatic pulse_reset();
        @(negedge CLOCK_50);
        #2 RESET = 1'b1;
        #1;
        chk("rst_gate", 64'(voiceGate), 64'd0);
        chk("rst_note", 64'(voiceNote), 64'd0);
        chk("rst_vel", 64'(voiceVelocity), 64'd0);
        chk("rst_event", 64'(noteEvent), 64'd0);
        chk("rst_evoice", 64'(eventVoice), 64'd0);
        #2 RESET = 1'b0;
        m_reset();
    endtask

    task automatic send_seq(input logic [7:0] s[$]);
        foreach (s[i]) send_byte(s[i]);
        idle_cycle();
    endtask

    initial begin
        logic [7:0] b;
        m_reset();
        RESET = 1'b1;
        repeat (2) @(posedge CLOCK_50);
        pulse_reset();

        send_seq('{8'h90, 8'h3C, 8'h64});
        send_seq('{8'h40, 8'h50, 8'h3C, 8'h00});

        pulse_reset();
        send_seq('{8'h90, 8'd60, 8'h11, 8'd61, 8'h12, 8'd62, 8'h13, 8'd63, 8'h14});
        send_seq('{8'd64, 8'h15, 8'd65, 8'h16});
        send_seq('{8'd62, 8'h33, 8'h80, 8'd63, 8'h00, 8'd99, 8'h00});

        pulse_reset();
        send_seq('{8'h90, 8'h3C, 8'hF8, 8'h64});
        send_seq('{8'h90, 8'h3C, 8'hB0, 8'h40, 8'h41, 8'h42});

        pulse_reset();
        send_byte(8'h90);
        pulse_reset();
        send_seq('{8'h3C, 8'h64});
        chk("after_rst_gate", 64'(voiceGate), 64'd0);
        chk("after_rst_note", 64'(voiceNote), 64'd0);

        send_seq('{8'h91, 8'h3C, 8'h64, 8'h90, 8'h3C, 8'h64});

        for (int i = 0; i < 400; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 10)      b = 8'h90 | 8'($urandom_range(0, 15));
            else if (r < 15) b = 8'h80 | 8'($urandom_range(0, 15));
            else if (r < 18) b = 8'hF8 + 8'($urandom_range(0, 7));
            else if (r < 20) b = 8'hA0 + 8'($urandom_range(0, 87));
            else if ($urandom_range(0, 5) == 0) b = 8'h00;
            else b = 8'd60 + 8'($urandom_range(0, 5));
            send_byte(b);
            if ($urandom_range(0, 3) == 0) idle_cycle();
        end

        chk("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/midi_voice_allocator.md
# midi_voice_allocator

Consumes the byte stream produced by the MIDI UART byte receiver and parses Note On and Note Off messages, including running status. It schedules the synth's fixed pool of voice generators, assigning each note to a voice and stealing the least-recently-allocated voice when the pool is full. It sits between the MIDI receiver and the per-voice oscillator/envelope channels, and drives their gate, note and velocity inputs.

## Interface
- VOICES, 4: number of voice channels, 2..8; `VW = $clog2(VOICES)`.
- CHANNEL, 4'd0: MIDI channel accepted when channel filtering is compiled in.

- CLOCK_50  in  1  system clock, 50 MHz.
- RESET  in  1  asynchronous, active-high reset.
- isByteAvailable  in  1  one-cycle pulse; byteValue is valid in that cycle.
- byteValue  in  8  received MIDI byte.
- voiceGate  out  VOICES  bit v high while voice v holds a sounding note.
- voiceNote  out  7*VOICES  note number of voice v, in bits [7v+6:7v].
- voiceVelocity  out  7*VOICES  note-on velocity of voice v, in bits [7v+6:7v].
- noteEvent  out  1  one-cycle pulse when a note message has been applied.
- eventVoice  out  VW  index of the voice changed by the last noteEvent.

## Operation
- Parser states:
  - IDLE: no running status.
  - DATA1: waiting for the note number.
  - DATA2: waiting for the velocity.
- Status bytes 0x80–0x9F (bit 7 set) set runningStatus (on/off plus channel) and move to DATA1 from any state.
- Status bytes 0xA0–0xF7 clear running status and move to IDLE.
- Realtime bytes 0xF8–0xFF are ignored. They leave the state and partial message untouched.
- Data byte in IDLE: ignored.
- Data byte in DATA1: latched as the note; move to DATA2.
- Data byte in DATA2: completes the message; return to DATA1 (running status).
- A Note On with velocity 0 is treated as a Note Off.
- Note On, note n, velocity k:
  1. If a gated voice already holds n, retrigger that voice: velocity becomes k, gate stays 1.
  2. Otherwise, if any gate is 0, take the lowest-index free voice.
  3. Otherwise, steal the voice with rank VOICES-1.
  - The chosen voice gets note n, velocity k, gate 1.
- Note Off, note n: clear the gate of every gated voice holding n. Note and velocity are retained. eventVoice reports the lowest such index.
- A Note Off that matches no voice produces no noteEvent and no change.
- LRU ranks:
  - Each voice has a VW-bit rank; 0 is newest. Ranks always form a permutation.
  - On Note On to voice v with rank r, every voice with rank < r increments, and v becomes 0.
  - Retrigger updates ranks the same way. Note Off leaves ranks unchanged.

## Timing
- Reset values:
  - voiceGate = 0.
  - voiceNote and voiceVelocity = 0.
  - noteEvent = 0, eventVoice = 0.
  - Parser in IDLE; rank[v] = v.
- Single-cycle processing: on the CLOCK_50 edge where isByteAvailable=1 with the completing byte, the parser, voice registers and ranks update together.
- noteEvent is high for exactly the following cycle. Latency from the pulse to the output is 1 cycle.
- isByteAvailable pulses on consecutive cycles must each be processed. There is no backpressure.
- RESET asserted mid-message discards the partial message and running status immediately (asynchronous).

## Configuration
- MIDI_CHANNEL_FILTER_EN defined:
  - Note status bytes whose low nibble ≠ CHANNEL clear running status and go to IDLE, so their data bytes are ignored.
- MIDI_CHANNEL_FILTER_EN undefined (omni mode):
  - Note messages on all 16 channels are accepted.
  - CHANNEL is unused.

## Test plan
- 0x90,0x3C,0x64 -> one cycle after the last pulse: voiceGate=4'b0001, voice0 note 0x3C, velocity 0x64; noteEvent pulses with eventVoice=0.
- 0x90,0x3C,0x64 then running-status 0x40,0x50 then 0x3C,0x00 -> voice1 gets 0x40; voice0's gate clears; voiceGate=4'b0010.
- Notes 60,61,62,63 then 64 (VOICES=4) -> all gates high; voice0 is stolen (note 64); a further note 65 steals voice1.
- 0x90,0x3C,0xF8,0x64 -> the realtime byte is ignored and the note starts normally. 0x90,0x3C,0xB0,0x40 -> no noteEvent.
- RESET pulsed between 0x90 and 0x3C, then 0x3C,0x64 -> no noteEvent; all outputs stay 0.
- With MIDI_CHANNEL_FILTER_EN and CHANNEL=0: 0x91,0x3C,0x64 -> no change; 0x90,0x3C,0x64 -> voice0 gated.
